filter_sequencer: RTL and testbench

//  Control block in front of the filter-select datapath. Drives filter_num and

---
 rtl/filter_sequencer.sv | 116 +++++++++++
 tb/tb_filter_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_sequencer.sv
// Filter-select sequencer: commits filter_num/freq_flag only between video frames,
// taking requests from a debounced push-button or an auto-cycle frame counter.
module filter_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned AUTO_FRAMES     = 60,
   parameter int unsigned NUM_FILTERS     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_n,
   input  logic       auto_mode,
   input  logic [1:0] freq_flag_in,
   input  logic       mon_valid,
   input  logic       mon_ready,
   input  logic       mon_sop,
   input  logic       mon_eop,
   output logic [1:0] filter_num,
   output logic [1:0] freq_flag,
   output logic       frame_done,
   output logic       pending
);

   localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned FC_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
   localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [FC_W-1:0] FC_LAST  = FC_W'(AUTO_FRAMES - 1);
   localparam logic [1:0]      REQ_LAST = 2'(NUM_FILTERS - 1);

   localparam logic [0:0] GAP      = 1'b0;
   localparam logic [0:0] IN_FRAME = 1'b1;

   logic            btn_meta;
   logic            btn_sync;
   logic            btn_stable;
   logic [DB_W-1:0] db_cnt;
   logic [FC_W-1:0] frame_cnt;
   logic [1:0]      req_filter;
   logic [1:0]      req_freq;
   logic [0:0]      state;
   logic            beat;
   logic            press;
   logic            tick;
   logic            sop_start;

   always_comb begin
      beat      = mon_valid & mon_ready;
      sop_start = beat & mon_sop & ~mon_eop;
      press     = (btn_sync != btn_stable) && (db_cnt == DB_LAST) && !btn_sync;
      tick      = auto_mode && beat && mon_eop && (frame_cnt == FC_LAST);
   end

   // Synchroniser and debouncer; idle (released) level is high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_meta   <= 1'b1;
         btn_sync   <= 1'b1;
         btn_stable <= 1'b1;
         db_cnt     <= '0;
      end else begin
         btn_meta <= btn_n;
         btn_sync <= btn_meta;
         if (btn_sync == btn_stable) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            btn_stable <= btn_sync;
            db_cnt     <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_cnt  <= '0;
         req_filter <= '0;
         req_freq   <= '0;
      end else begin
         req_freq <= freq_flag_in;
         if (!auto_mode) begin
            frame_cnt <= '0;
         end else if (beat && mon_eop) begin
            frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + 1'b1;
         end
         if (press || tick) begin
            req_filter <= (req_filter == REQ_LAST) ? '0 : req_filter + 2'd1;
         end
      end
   end

   // The sop edge itself holds the outputs, so the value the sop beat saw
   // is the value kept for the whole packet.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= GAP;
         filter_num <= '0;
         freq_flag  <= '0;
         frame_done <= 1'b0;
         pending    <= 1'b0;
      end else begin
         frame_done <= beat & mon_eop;
         pending    <= (req_filter != filter_num) | (req_freq != freq_flag);
         if (state == GAP) begin
            if (sop_start) begin
               state <= IN_FRAME;
            end else begin
               filter_num <= req_filter;
               freq_flag  <= req_freq;
            end
         end else if (beat && mon_eop) begin
            state <= GAP;
         end
      end
   end

endmodule

// File: tb/tb_filter_sequencer.sv
// Randomised scoreboard bench for filter_sequencer: a frame-level model predicts
// the filter/pitch code each packet must carry; a monitor checks every frame.
module tb_filter_sequencer;

   localparam int unsigned DB = 8;
   localparam int unsigned AF = 2;
   localparam int unsigned NF = 4;

   logic       clk;
   logic       reset;
   logic       btn_n;
   logic       auto_mode;
   logic [1:0] freq_flag_in;
   logic       mon_valid;
   logic       mon_ready;
   logic       mon_sop;
   logic       mon_eop;
   logic [1:0] filter_num;
   logic [1:0] freq_flag;
   logic       frame_done;
   logic       pending;

   filter_sequencer #(
      .DEBOUNCE_CYCLES(DB),
      .AUTO_FRAMES    (AF),
      .NUM_FILTERS    (NF)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_n       (btn_n),
      .auto_mode   (auto_mode),
      .freq_flag_in(freq_flag_in),
      .mon_valid   (mon_valid),
      .mon_ready   (mon_ready),
      .mon_sop     (mon_sop),
      .mon_eop     (mon_eop),
      .filter_num  (filter_num),
      .freq_flag   (freq_flag),
      .frame_done  (frame_done),
      .pending     (pending)
   );

   typedef struct {
      int unsigned f;
      int unsigned q;
   } exp_t;

   exp_t        sb[$];
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned model_req = 0;
   int unsigned model_freq = 0;
   int unsigned auto_cnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: samples just after each edge, sees the inputs consumed and the state produced.
   logic       in_pkt = 1'b0;
   logic [1:0] cap_f  = '0;
   logic [1:0] cap_q  = '0;
   always @(posedge clk) begin
      exp_t e;
      logic bt;
      #1;
      if (!reset) begin
         in_pkt = 1'b0;
      end else begin
         bt = mon_valid & mon_ready;
         chk("frame_done", frame_done, bt & mon_eop);
         if (bt && mon_sop) begin
            cap_f  = filter_num;
            cap_q  = freq_flag;
            in_pkt = !mon_eop;
         end else if (in_pkt) begin
            chk("hold_filter", filter_num, cap_f);
            chk("hold_freq", freq_flag, cap_q);
            if (bt && mon_eop) in_pkt = 1'b0;
         end
         if (frame_done) begin
            if (sb.size() == 0) begin
               chk("unexpected_frame", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("frame_filter", cap_f, e.f);
               chk("frame_freq", cap_q, e.q);
            end
         end
      end
   end

   task automatic model_eop();
      if (auto_mode) begin
         auto_cnt++;
         if (auto_cnt == AF) begin
            auto_cnt  = 0;
            model_req = (model_req + 1) % NF;
         end
      end
   endtask

   task automatic idle_and_push();
      freq_flag_in = 2'($urandom_range(0, 3));
      model_freq   = freq_flag_in;
      mon_valid    = 1'b0;
      repeat (3) @(negedge clk);
      sb.push_back('{model_req, model_freq});
   endtask

   task automatic drive_beat(input logic sop, input logic eop);
      mon_valid = 1'b1;
      mon_ready = 1'b1;
      mon_sop   = sop;
      mon_eop   = eop;
      @(negedge clk);
      mon_valid = 1'b0;
      mon_sop   = 1'b0;
      mon_eop   = 1'b0;
   endtask

   task automatic send_frame(input int unsigned len);
      idle_and_push();
      for (int unsigned i = 0; i < len; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            mon_valid = 1'b1;
            mon_ready = 1'b0;
            mon_sop   = (i == 0);
            mon_eop   = (i == len - 1);
            @(negedge clk);
         end
         freq_flag_in = 2'($urandom_range(0, 3));
         drive_beat(i == 0, i == len - 1);
      end
      model_eop();
   endtask

   task automatic press();
      btn_n = 1'b0;
      repeat (DB + 6) @(negedge clk);
      btn_n = 1'b1;
      repeat (DB + 6) @(negedge clk);
      model_req = (model_req + 1) % NF;
   endtask

   initial begin
      int unsigned old_f;
      reset = 1'b0; btn_n = 1'b1; auto_mode = 1'b0; freq_flag_in = '0;
      mon_valid = 1'b0; mon_ready = 1'b1; mon_sop = 1'b0; mon_eop = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_filter", filter_num, 0);
      chk("rst_freq", freq_flag, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_pending", pending, 0);

      // Pitch class follows freq_flag_in with two-cycle latency in the gap.
      reset = 1'b1;
      freq_flag_in = 2'd2;
      repeat (2) @(negedge clk);
      chk("t1_freq", freq_flag, 2);
      chk("t1_filter", filter_num, 0);
      repeat (2) @(negedge clk);
      chk("t1_pending", pending, 0);

      send_frame(3);

      // Press mid-frame waits for the gap.
      idle_and_push();
      drive_beat(1'b1, 1'b0);
      drive_beat(1'b0, 1'b0);
      press();
      chk("t2_filter_held", filter_num, 0);
      chk("t2_pending", pending, 1);
      drive_beat(1'b0, 1'b1);
      chk("t2_filter_gap_entry", filter_num, 0);
      @(negedge clk);
      chk("t2_filter_commit", filter_num, 1);
      repeat (2) @(negedge clk);
      chk("t2_pending_clear", pending, 0);

      // Short glitches never reach the debounce threshold.
      for (int unsigned g = 0; g < 6; g++) begin
         btn_n = 1'b0;
         repeat ($urandom_range(1, DB - 2)) @(negedge clk);
         btn_n = 1'b1;
         repeat ($urandom_range(3, 6)) @(negedge clk);
      end
      repeat (DB + 4) @(negedge clk);
      chk("t3_glitch_filter", filter_num, model_req);
      send_frame(2);
      while (model_req != 3) press();
      for (int unsigned p = 0; p < 4; p++) begin
         press();
         send_frame($urandom_range(1, 4));
      end

      // Auto mode from request 0.
      while (model_req != 0) press();
      auto_mode = 1'b1;
      for (int unsigned fr = 0; fr < 7; fr++) send_frame($urandom_range(2, 4));
      // Press accepted on the same edge as the ticking eop beat.
      idle_and_push();
      drive_beat(1'b1, 1'b0);
      drive_beat(1'b0, 1'b0);
      btn_n = 1'b0;
      repeat (DB + 1) @(negedge clk);
      drive_beat(1'b0, 1'b1);
      model_eop();
      repeat (DB + 4) @(negedge clk);
      btn_n = 1'b1;
      repeat (DB + 6) @(negedge clk);
      chk("t4_coincide", filter_num, model_req);
      auto_mode = 1'b0;
      auto_cnt  = 0;
      send_frame(3);

      // Backpressured eop does not end the frame.
      idle_and_push();
      old_f = model_req;
      drive_beat(1'b1, 1'b0);
      press();
      mon_valid = 1'b1; mon_ready = 1'b0; mon_eop = 1'b1;
      repeat (5) @(negedge clk);
      chk("t5_bp_filter", filter_num, old_f);
      chk("t5_bp_pending", pending, 1);
      drive_beat(1'b0, 1'b1);
      chk("t5_gap_entry", filter_num, old_f);
      @(negedge clk);
      chk("t5_commit", filter_num, model_req);

      // Single-beat packet leaves the sequencer in the gap.
      idle_and_push();
      drive_beat(1'b1, 1'b1);
      press();
      chk("t5_single_beat_gap", filter_num, model_req);

      for (int unsigned r = 0; r < 8; r++) begin
         if ($urandom_range(0, 1) == 1) press();
         send_frame($urandom_range(1, 5));
      end

      // Reset in the middle of a frame.
      while (model_req != 2) press();
      idle_and_push();
      drive_beat(1'b1, 1'b0);
      drive_beat(1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("t6_filter", filter_num, 0);
      chk("t6_freq", freq_flag, 0);
      chk("t6_frame_done", frame_done, 0);
      chk("t6_pending", pending, 0);
      sb.delete();
      model_req = 0;
      auto_cnt  = 0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      send_frame(3);

      repeat (4) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
